// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 16-bit CPU control path.
//   - cpu_state_t : controller FSM states
//   - OP_* / EXT_*: instruction op and ext field encodings
//   - CC_*        : branch condition codes (rd field of Bcond)
//   - FLAG_*      : bit positions of {C,L,F,Z,N} in flags/PSR
package cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_LDWB   = 2'd3
  } cpu_state_t;

  // op field [15:12]
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // ext field [7:4] for register and memory formats
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  // Branch condition codes
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;

  // Flag bit indices within {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/cpu_controller_imm_ext.sv
// imm_ext: combinational immediate and branch displacement extender.
//   op   in  4      : instruction op field
//   imm8 in  8      : instruction low byte
//   imm  out DATA_W : ALU immediate (sign/zero/upper extended by op)
//   disp out DATA_W : imm8 sign-extended, used as branch displacement
module imm_ext
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [7:0]        imm8,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] disp
);

  always_comb begin
    imm = '0;
    case (op)
      OP_ADDI, OP_SUBI, OP_CMPI:         imm = {{(DATA_W-8){imm8[7]}}, imm8};
      OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: imm = {{(DATA_W-8){1'b0}}, imm8};
      OP_LUI:                            imm = {imm8, {(DATA_W-8){1'b0}}};
      default:                           imm = '0;
    endcase
  end

  assign disp = {{(DATA_W-8){imm8[7]}}, imm8};

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle FETCH/DECODE/EXEC/LDWB control FSM.
// Owns the instruction register and the PSR; all control outputs are
// decoded from the state and IR registers only (no path from flags_in).
//   clk, reset (async, active-low)
//   instr_in     : fetched instruction word (valid in DECODE)
//   flags_in     : ALU flags {C,L,F,Z,N}, latched into PSR at end of EXEC
//   wEnable      : one-hot register write enable
//   opcode, Imm_in, Imm_select, Rdest_select, Rsrc_select : ALU/regfile controls
//   ram_we, addr_sel, wb_sel, pc_en, pc_sel, branch_disp, ir_load : datapath controls
//   state_dbg, psr_dbg : current FSM state and PSR for observation
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [4:0]        flags_in,
  output logic [NREGS-1:0]  wEnable,
  output logic [7:0]        opcode,
  output logic [3:0]        Rdest_select,
  output logic [3:0]        Rsrc_select,
  output logic [DATA_W-1:0] Imm_in,
  output logic              Imm_select,
  output logic              ram_we,
  output logic              addr_sel,
  output logic              wb_sel,
  output logic              pc_en,
  output logic              pc_sel,
  output logic [DATA_W-1:0] branch_disp,
  output logic              ir_load,
  output cpu_state_t        state_dbg,
  output logic [4:0]        psr_dbg
);

  cpu_state_t        state, state_nxt;
  logic [DATA_W-1:0] ir;
  logic [4:0]        psr;

  logic [3:0] f_op, f_rd, f_ext, f_rs;
  logic       alu_reg, alu_imm, is_alu, is_cmp, sets_flags;
  logic       is_load, is_stor, is_bcond, taken;
  logic [NREGS-1:0] rd_onehot;

  assign f_op  = ir[15:12];
  assign f_rd  = ir[11:8];
  assign f_ext = ir[7:4];
  assign f_rs  = ir[3:0];

  // Instruction class decode from IR
  always_comb begin
    alu_reg    = (f_op == OP_REG) &&
                 (f_ext inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_SUB, EXT_CMP, EXT_MOV});
    alu_imm    = f_op inside {OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI, OP_LUI};
    is_alu     = alu_reg || alu_imm;
    is_cmp     = (alu_reg && (f_ext == EXT_CMP)) || (f_op == OP_CMPI);
    sets_flags = (alu_reg && (f_ext inside {EXT_ADD, EXT_SUB, EXT_CMP})) ||
                 (f_op inside {OP_ADDI, OP_SUBI, OP_CMPI});
    is_load    = (f_op == OP_MEM) && (f_ext == EXT_LOAD);
    is_stor    = (f_op == OP_MEM) && (f_ext == EXT_STOR);
    is_bcond   = (f_op == OP_BCOND);
    rd_onehot  = '0;
    rd_onehot[f_rd] = 1'b1;
  end

  // Branch condition evaluated on the registered PSR
  always_comb begin
    taken = 1'b0;
    case (f_rd)
      CC_EQ:   taken = psr[FLAG_Z];
      CC_NE:   taken = !psr[FLAG_Z];
      CC_CS:   taken = psr[FLAG_C];
      CC_CC:   taken = !psr[FLAG_C];
      CC_HI:   taken = psr[FLAG_L];
      CC_LS:   taken = !psr[FLAG_L];
      CC_LT:   taken = !psr[FLAG_N] && !psr[FLAG_Z];
      CC_GE:   taken = psr[FLAG_N] || psr[FLAG_Z];
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // State, IR and PSR registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      ir    <= '0;
      psr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE)
        ir <= instr_in;
      if ((state == S_EXEC) && sets_flags)
        psr <= flags_in;
    end
  end

  // Next state and per-state strobes. FETCH drives every strobe low, so
  // the async reset forcing FETCH also kills all writes immediately.
  always_comb begin
    state_nxt = state;
    wEnable   = '0;
    ram_we    = 1'b0;
    addr_sel  = 1'b0;
    wb_sel    = 1'b1;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    ir_load   = 1'b0;
    case (state)
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ir_load   = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (is_alu) begin
          if (!is_cmp) wEnable = rd_onehot;
          pc_en = 1'b1;
        end else if (is_stor) begin
          ram_we   = 1'b1;
          addr_sel = 1'b1;
          pc_en    = 1'b1;
        end else if (is_load) begin
          addr_sel  = 1'b1;
          state_nxt = S_LDWB;
        end else if (is_bcond) begin
          pc_en  = 1'b1;
          pc_sel = taken;
        end else begin
          pc_en = 1'b1;  // undefined encoding: NOP
        end
      end
      S_LDWB: begin
        addr_sel  = 1'b1;
        wEnable   = rd_onehot;
        wb_sel    = 1'b0;
        pc_en     = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Field-derived outputs straight from IR
  always_comb begin
    opcode = 8'h00;
    if (alu_reg)      opcode = {4'b0000, f_ext};
    else if (alu_imm) opcode = {f_op, 4'b0000};
  end

  assign Imm_select   = alu_imm;
  assign Rdest_select = f_rd;
  assign Rsrc_select  = f_rs;
  assign state_dbg    = state;
  assign psr_dbg      = psr;

  imm_ext #(.DATA_W(DATA_W)) u_imm_ext (
    .op   (f_op),
    .imm8 (ir[7:0]),
    .imm  (Imm_in),
    .disp (branch_disp)
  );

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] instr_in;
  logic [4:0]  flags_in;
  logic [15:0] wEnable;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_select, Rsrc_select;
  logic [15:0] Imm_in, branch_disp;
  logic        Imm_select, ram_we, addr_sel, wb_sel, pc_en, pc_sel, ir_load;
  cpu_state_t  state_dbg;
  logic [4:0]  psr_dbg;

  int checks = 0;
  int errors = 0;

  cpu_controller dut (
    .clk          (clk),
    .reset        (reset),
    .instr_in     (instr_in),
    .flags_in     (flags_in),
    .wEnable      (wEnable),
    .opcode       (opcode),
    .Rdest_select (Rdest_select),
    .Rsrc_select  (Rsrc_select),
    .Imm_in       (Imm_in),
    .Imm_select   (Imm_select),
    .ram_we       (ram_we),
    .addr_sel     (addr_sel),
    .wb_sel       (wb_sel),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .branch_disp  (branch_disp),
    .ir_load      (ir_load),
    .state_dbg    (state_dbg),
    .psr_dbg      (psr_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while in FETCH; returns at the EXEC negedge.
  task automatic fetch_decode(input logic [15:0] w);
    instr_in = w;
    chk("fetch_state", 32'(state_dbg), 32'(S_FETCH));
    chk("fetch_addr_sel", 32'(addr_sel), 32'd0);
    chk("fetch_pc_en", 32'(pc_en), 32'd0);
    @(negedge clk);
    chk("decode_state", 32'(state_dbg), 32'(S_DECODE));
    chk("decode_ir_load", 32'(ir_load), 32'd1);
    chk("decode_writes", {14'd0, pc_en, ram_we, wEnable}, 32'd0);
    @(negedge clk);
    chk("exec_state", 32'(state_dbg), 32'(S_EXEC));
    chk("exec_ir_load", 32'(ir_load), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    instr_in = 16'h0000;
    flags_in = 5'b00000;
    @(negedge clk);
    @(negedge clk);
    // reset state
    chk("rst_state", 32'(state_dbg), 32'(S_FETCH));
    chk("rst_wEnable", 32'(wEnable), 32'd0);
    chk("rst_strobes", {26'd0, ram_we, addr_sel, pc_en, pc_sel, ir_load, Imm_select}, 32'd0);
    chk("rst_wb_sel", 32'(wb_sel), 32'd1);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_imm", 32'(Imm_in), 32'd0);
    chk("rst_disp", 32'(branch_disp), 32'd0);
    chk("rst_sel", {24'd0, Rdest_select, Rsrc_select}, 32'd0);
    chk("rst_psr", 32'(psr_dbg), 32'd0);
    reset = 1'b1;

    // NOP 0x0000
    fetch_decode(16'h0000);
    chk("nop_pc_en", 32'(pc_en), 32'd1);
    chk("nop_pc_sel", 32'(pc_sel), 32'd0);
    chk("nop_writes", {15'd0, ram_we, wEnable}, 32'd0);
    @(negedge clk);

    // ADDI r3,#0xFF
    flags_in = 5'b10010;
    fetch_decode(16'h53FF);
    chk("addi_imm", 32'(Imm_in), 32'h0000FFFF);
    chk("addi_opcode", 32'(opcode), 32'h50);
    chk("addi_imm_sel", 32'(Imm_select), 32'd1);
    chk("addi_wEnable", 32'(wEnable), 32'h0008);
    chk("addi_wb_sel", 32'(wb_sel), 32'd1);
    chk("addi_pc_en", 32'(pc_en), 32'd1);
    chk("addi_rdest", 32'(Rdest_select), 32'd3);
    @(negedge clk);
    chk("addi_psr", 32'(psr_dbg), 32'h12);

    // LOAD r2,[r5]; flags change must not reach the PSR
    flags_in = 5'b00000;
    fetch_decode(16'h4205);
    chk("load_addr_sel", 32'(addr_sel), 32'd1);
    chk("load_rsrc", 32'(Rsrc_select), 32'd5);
    chk("load_exec_quiet", {15'd0, pc_en, wEnable}, 32'd0);
    @(negedge clk);
    chk("ldwb_state", 32'(state_dbg), 32'(S_LDWB));
    chk("ldwb_wEnable", 32'(wEnable), 32'h0004);
    chk("ldwb_wb_sel", 32'(wb_sel), 32'd0);
    chk("ldwb_addr_sel", 32'(addr_sel), 32'd1);
    chk("ldwb_pc", {30'd0, pc_en, pc_sel}, 32'b10);
    @(negedge clk);
    chk("load_psr_kept", 32'(psr_dbg), 32'h12);

    // STOR r7,[r1]
    fetch_decode(16'h4741);
    chk("stor_ram_we", 32'(ram_we), 32'd1);
    chk("stor_addr_sel", 32'(addr_sel), 32'd1);
    chk("stor_sel", {24'd0, Rdest_select, Rsrc_select}, 32'h71);
    chk("stor_wEnable", 32'(wEnable), 32'd0);
    chk("stor_pc_en", 32'(pc_en), 32'd1);
    @(negedge clk);
    chk("stor_ram_we_off", 32'(ram_we), 32'd0);

    // CMP r1,r2 with Z
    flags_in = 5'b00010;
    fetch_decode(16'h01B2);
    chk("cmp_opcode", 32'(opcode), 32'h0B);
    chk("cmp_imm_sel", 32'(Imm_select), 32'd0);
    chk("cmp_wEnable", 32'(wEnable), 32'd0);
    chk("cmp_pc_en", 32'(pc_en), 32'd1);
    @(negedge clk);
    chk("cmp_psr", 32'(psr_dbg), 32'h02);

    // BEQ -2, Z set -> taken
    flags_in = 5'b00000;
    fetch_decode(16'hC0FE);
    chk("beq_t_pc_sel", 32'(pc_sel), 32'd1);
    chk("beq_t_pc_en", 32'(pc_en), 32'd1);
    chk("beq_t_disp", 32'(branch_disp), 32'h0000FFFE);
    chk("beq_t_writes", {15'd0, ram_we, wEnable}, 32'd0);
    @(negedge clk);
    chk("beq_psr_kept", 32'(psr_dbg), 32'h02);

    // CMPI r1,#0 clearing Z, then BEQ not taken, BNE taken
    fetch_decode(16'hB100);
    chk("cmpi_wEnable", 32'(wEnable), 32'd0);
    chk("cmpi_opcode", 32'(opcode), 32'hB0);
    @(negedge clk);
    chk("cmpi_psr", 32'(psr_dbg), 32'h00);
    fetch_decode(16'hC0FE);
    chk("beq_nt_pc_sel", 32'(pc_sel), 32'd0);
    chk("beq_nt_pc_en", 32'(pc_en), 32'd1);
    @(negedge clk);
    fetch_decode(16'hC1FE);
    chk("bne_pc_sel", 32'(pc_sel), 32'd1);
    @(negedge clk);
    // LT with N=0,Z=0 taken; unconditional with positive displacement
    fetch_decode(16'hCC10);
    chk("blt_pc_sel", 32'(pc_sel), 32'd1);
    @(negedge clk);
    fetch_decode(16'hCE05);
    chk("buc_pc_sel", 32'(pc_sel), 32'd1);
    chk("buc_disp", 32'(branch_disp), 32'h0005);
    @(negedge clk);
    // undefined condition code 0110 never taken
    fetch_decode(16'hC605);
    chk("bund_pc_sel", 32'(pc_sel), 32'd0);
    @(negedge clk);

    // LUI r4,#0x12
    fetch_decode(16'hF412);
    chk("lui_imm", 32'(Imm_in), 32'h1200);
    chk("lui_opcode", 32'(opcode), 32'hF0);
    chk("lui_wEnable", 32'(wEnable), 32'h0010);
    @(negedge clk);

    // ANDI r2,#0x80 is zero-extended
    fetch_decode(16'h1280);
    chk("andi_imm", 32'(Imm_in), 32'h0080);
    chk("andi_wEnable", 32'(wEnable), 32'h0004);
    @(negedge clk);

    // Undefined register-format ext behaves as NOP
    fetch_decode(16'h0A06);
    chk("undef_writes", {15'd0, ram_we, wEnable}, 32'd0);
    chk("undef_pc", {30'd0, pc_en, pc_sel}, 32'b10);
    chk("undef_opcode", 32'(opcode), 32'd0);
    @(negedge clk);

    // ADD r1,r2 with all flags, then reset during LDWB of a LOAD
    flags_in = 5'b11111;
    fetch_decode(16'h0152);
    chk("add_wEnable", 32'(wEnable), 32'h0002);
    chk("add_opcode", 32'(opcode), 32'h05);
    @(negedge clk);
    chk("add_psr", 32'(psr_dbg), 32'h1F);
    flags_in = 5'b00000;
    fetch_decode(16'h4205);
    @(negedge clk);
    chk("ldwb2_wEnable", 32'(wEnable), 32'h0004);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_wEnable", 32'(wEnable), 32'd0);
    chk("arst_pc_en", 32'(pc_en), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'(S_FETCH));
    chk("arst_psr", 32'(psr_dbg), 32'd0);
    chk("arst_ir", {24'd0, Rdest_select, Rsrc_select}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    instr_in = 16'h0000;
    chk("post_rst_state", 32'(state_dbg), 32'(S_FETCH));
    @(negedge clk);
    chk("post_rst_decode", 32'(state_dbg), 32'(S_DECODE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
